// File: rtl/fork_join_ctrl_if.sv
// Bus bundle for fork_join_ctrl.
//   master : drives fork requests (start, mode, thread_en, thread_dly,
//            wait_fork, disable_fork) and observes the thread/join status.
//   slave  : the controller side; receives requests, drives thread_active,
//            thread_done, parent_blocked, join_done, wait_done, disabled,
//            busy and elapsed.
interface fork_join_ctrl_if #(
    parameter int NUM_THREADS = 4,
    parameter int DLY_W       = 8
);
    logic                         start;
    logic [1:0]                   mode;
    logic [NUM_THREADS-1:0]       thread_en;
    logic [NUM_THREADS*DLY_W-1:0] thread_dly;
    logic                         wait_fork;
    logic                         disable_fork;
    logic [NUM_THREADS-1:0]       thread_active;
    logic [NUM_THREADS-1:0]       thread_done;
    logic                         parent_blocked;
    logic                         join_done;
    logic                         wait_done;
    logic                         disabled;
    logic                         busy;
    logic [15:0]                  elapsed;

    modport master (
        output start, mode, thread_en, thread_dly, wait_fork, disable_fork,
        input  thread_active, thread_done, parent_blocked, join_done,
               wait_done, disabled, busy, elapsed
    );

    modport slave (
        input  start, mode, thread_en, thread_dly, wait_fork, disable_fork,
        output thread_active, thread_done, parent_blocked, join_done,
               wait_done, disabled, busy, elapsed
    );
endinterface

// File: rtl/fork_join_ctrl.sv
// fork_join_ctrl: hardware model of fork/join process control.
// A start forks up to NUM_THREADS delay-timer threads; the parent resumes
// (join_done) according to the latched join mode: join, join_any, join_none.
// Also supports wait fork (wait_fork/wait_done) and disable fork
// (disable_fork/disabled).
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : fork_join_ctrl_if.slave (requests in, status/pulses out)
module fork_join_ctrl #(
    parameter int NUM_THREADS = 4,
    parameter int DLY_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    fork_join_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_BLOCKED  = 2'd1,
        S_DETACHED = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DLY_W-1:0]       cnt [NUM_THREADS];
    logic [NUM_THREADS-1:0] active;
    logic [NUM_THREADS-1:0] done_q;
    logic [NUM_THREADS-1:0] expiring;
    logic [NUM_THREADS-1:0] remaining;
    logic [1:0]             mode_q;
    logic                   jn_pend;   // join_none / empty fork: join_done next cycle
    logic                   join_q;
    logic                   wait_q;
    logic                   dis_q;
    logic                   served;    // wait already answered, blocks re-fire
    logic [15:0]            elapsed_q;

    logic accept;
    logic empty;
    logic any_exp;
    logic none_left;
    logic join_fire;
    logic wait_fire;
    logic busy_w;

    // Threads whose counter reaches zero on this edge.
    always_comb begin
        expiring = '0;
        for (int unsigned i = 0; i < NUM_THREADS; i++)
            expiring[i] = active[i] && (cnt[i] == DLY_W'(1));
    end

    assign remaining = active & ~expiring;
    assign any_exp   = |expiring;
    assign none_left = (remaining == '0);
    assign busy_w    = |active;
    assign empty     = (bus.thread_en == '0);
    assign accept    = (state == S_IDLE) && bus.start && !bus.disable_fork;

    // join_any resumes on the first expiry; join (and mode 11) on the last.
    assign join_fire = (state == S_BLOCKED) && !bus.disable_fork && any_exp &&
                       ((mode_q == 2'b01) || none_left);

    // A disable also satisfies a pending wait.
    assign wait_fire = bus.wait_fork && !served &&
                       (bus.disable_fork || !busy_w || (any_exp && none_left));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.disable_fork) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && !empty)
                        state_nxt = (bus.mode == 2'b10) ? S_DETACHED : S_BLOCKED;
                end
                S_BLOCKED: begin
                    if (join_fire)
                        state_nxt = none_left ? S_IDLE : S_DETACHED;
                end
                S_DETACHED: begin
                    if (none_left) state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_THREADS; i++) cnt[i] <= '0;
            active    <= '0;
            done_q    <= '0;
            mode_q    <= '0;
            jn_pend   <= 1'b0;
            join_q    <= 1'b0;
            wait_q    <= 1'b0;
            dis_q     <= 1'b0;
            served    <= 1'b0;
            elapsed_q <= '0;
        end else begin
            done_q <= '0;
            join_q <= 1'b0;
            dis_q  <= 1'b0;
            wait_q <= wait_fire;
            served <= bus.wait_fork && (served || wait_fire);

            if (accept)
                elapsed_q <= '0;
            else if (elapsed_q != 16'hFFFF)
                elapsed_q <= elapsed_q + 16'd1;

            if (bus.disable_fork) begin
                // Kill everything, including threads expiring on this edge.
                for (int unsigned i = 0; i < NUM_THREADS; i++) cnt[i] <= '0;
                active  <= '0;
                jn_pend <= 1'b0;
                dis_q   <= 1'b1;
            end else begin
                for (int unsigned i = 0; i < NUM_THREADS; i++) begin
                    if (expiring[i]) begin
                        cnt[i]    <= '0;
                        active[i] <= 1'b0;
                        done_q[i] <= 1'b1;
                    end else if (active[i]) begin
                        cnt[i] <= cnt[i] - DLY_W'(1);
                    end
                end
                join_q  <= join_fire || jn_pend;
                jn_pend <= 1'b0;
                // IDLE never holds active threads, so loading cannot collide
                // with the expiry updates above.
                if (accept) begin
                    mode_q  <= bus.mode;
                    jn_pend <= empty || (bus.mode == 2'b10);
                    for (int unsigned i = 0; i < NUM_THREADS; i++) begin
                        if (bus.thread_en[i]) begin
                            active[i] <= 1'b1;
                            cnt[i]    <= (bus.thread_dly[i*DLY_W +: DLY_W] == '0) ?
                                         DLY_W'(1) : bus.thread_dly[i*DLY_W +: DLY_W];
                        end
                    end
                end
            end
        end
    end

    assign bus.thread_active  = active;
    assign bus.thread_done    = done_q;
    assign bus.parent_blocked = (state == S_BLOCKED) || jn_pend;
    assign bus.join_done      = join_q;
    assign bus.wait_done      = wait_q;
    assign bus.disabled       = dis_q;
    assign bus.busy           = busy_w;
    assign bus.elapsed        = elapsed_q;

endmodule

// File: tb/tb_fork_join_ctrl.sv
module tb_fork_join_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fork_join_ctrl_if #(.NUM_THREADS(4), .DLY_W(8)) bif ();

    fork_join_ctrl #(.NUM_THREADS(4), .DLY_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int c_join, c_wait, c_dis, c_tdone;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tick n cycles, counting output pulses seen along the way.
    task automatic tick_cnt(input int n);
        c_join = 0; c_wait = 0; c_dis = 0; c_tdone = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            c_join  += int'(bif.join_done);
            c_wait  += int'(bif.wait_done);
            c_dis   += int'(bif.disabled);
            c_tdone += $countones(bif.thread_done);
        end
    endtask

    task automatic do_start(input logic [1:0] m, input logic [3:0] en, input logic [31:0] d);
        bif.mode       = m;
        bif.thread_en  = en;
        bif.thread_dly = d;
        bif.start      = 1'b1;
        tick();
        bif.start      = 1'b0;
        bif.thread_en  = '0;
    endtask

    initial begin
        rst_n            = 1'b0;
        bif.start        = 1'b0;
        bif.mode         = 2'b00;
        bif.thread_en    = '0;
        bif.thread_dly   = '0;
        bif.wait_fork    = 1'b0;
        bif.disable_fork = 1'b0;
        tick(); tick();

        chk("rst_active",  32'(bif.thread_active), 32'h0);
        chk("rst_done",    32'(bif.thread_done), 32'h0);
        chk("rst_blocked", 32'(bif.parent_blocked), 32'h0);
        chk("rst_join",    32'(bif.join_done), 32'h0);
        chk("rst_busy",    32'(bif.busy), 32'h0);
        chk("rst_elapsed", 32'(bif.elapsed), 32'h0);
        rst_n = 1'b1;
        tick();

        // join_any {40,70,60}; wait_fork after join_done; start while busy
        do_start(2'b01, 4'b0111, {8'd0, 8'd60, 8'd70, 8'd40});
        chk("ja1_el0",      32'(bif.elapsed), 32'd0);
        chk("ja1_blocked0", 32'(bif.parent_blocked), 32'h1);
        chk("ja1_active0",  32'(bif.thread_active), 32'h7);
        tick_cnt(39);
        chk("ja1_join_early", 32'(c_join), 32'd0);
        chk("ja1_done_early", 32'(c_tdone), 32'd0);
        tick();
        chk("ja1_el40",      32'(bif.elapsed), 32'd40);
        chk("ja1_join40",    32'(bif.join_done), 32'h1);
        chk("ja1_done40",    32'(bif.thread_done), 32'h1);
        chk("ja1_blocked40", 32'(bif.parent_blocked), 32'h0);
        bif.wait_fork = 1'b1;
        do_start(2'b00, 4'b1000, {8'd5, 8'd0, 8'd0, 8'd0});
        chk("ja1_ign_el",     32'(bif.elapsed), 32'd41);
        chk("ja1_ign_active", 32'(bif.thread_active), 32'h6);
        tick_cnt(18);
        chk("ja1_quiet_a", 32'(c_join + c_wait + c_tdone), 32'd0);
        tick();
        chk("ja1_done60", 32'(bif.thread_done), 32'h4);
        tick_cnt(9);
        chk("ja1_quiet_b", 32'(c_join + c_wait + c_tdone), 32'd0);
        tick();
        chk("ja1_done70", 32'(bif.thread_done), 32'h2);
        chk("ja1_wait70", 32'(bif.wait_done), 32'h1);
        bif.wait_fork = 1'b0;
        tick();
        chk("ja1_busy71", 32'(bif.busy), 32'h0);
        chk("ja1_wait71", 32'(bif.wait_done), 32'h0);

        // join_none {15,40}, disable at elapsed 20
        do_start(2'b10, 4'b0011, {8'd0, 8'd0, 8'd40, 8'd15});
        chk("jn_join0", 32'(bif.join_done), 32'h0);
        tick();
        chk("jn_join1", 32'(bif.join_done), 32'h1);
        tick_cnt(13);
        chk("jn_done_early", 32'(c_tdone), 32'd0);
        tick();
        chk("jn_done15", 32'(bif.thread_done), 32'h1);
        chk("jn_busy15", 32'(bif.busy), 32'h1);
        tick_cnt(5);
        chk("jn_el20", 32'(bif.elapsed), 32'd20);
        bif.disable_fork = 1'b1;
        tick();
        bif.disable_fork = 1'b0;
        chk("jn_dis21",     32'(bif.disabled), 32'h1);
        chk("jn_active21",  32'(bif.thread_active), 32'h0);
        chk("jn_done21",    32'(bif.thread_done), 32'h0);
        chk("jn_blocked21", 32'(bif.parent_blocked), 32'h0);
        tick_cnt(30);
        chk("jn_after_dis", 32'(c_tdone + c_join + c_dis), 32'd0);

        // join {5,9}
        do_start(2'b00, 4'b0011, {8'd0, 8'd0, 8'd9, 8'd5});
        for (int i = 0; i < 9; i++) begin
            chk("j_blocked", 32'(bif.parent_blocked), 32'h1);
            chk("j_nojoin",  32'(bif.join_done), 32'h0);
            chk("j_tdone",   32'(bif.thread_done), (i == 5) ? 32'h1 : 32'h0);
            tick();
        end
        chk("j_el9",      32'(bif.elapsed), 32'd9);
        chk("j_join9",    32'(bif.join_done), 32'h1);
        chk("j_done9",    32'(bif.thread_done), 32'h2);
        chk("j_blocked9", 32'(bif.parent_blocked), 32'h0);
        tick();
        chk("j_join10", 32'(bif.join_done), 32'h0);

        // join_any {2,10,6} with wait_fork
        do_start(2'b01, 4'b0111, {8'd0, 8'd6, 8'd10, 8'd2});
        bif.wait_fork = 1'b1;
        tick();
        chk("ja2_join1", 32'(bif.join_done), 32'h0);
        tick();
        chk("ja2_join2", 32'(bif.join_done), 32'h1);
        chk("ja2_done2", 32'(bif.thread_done), 32'h1);
        tick_cnt(7);
        chk("ja2_wait_early", 32'(c_wait), 32'd0);
        chk("ja2_join_once",  32'(c_join), 32'd0);
        chk("ja2_done6",      32'(c_tdone), 32'd1);
        tick();
        chk("ja2_wait10", 32'(bif.wait_done), 32'h1);
        chk("ja2_done10", 32'(bif.thread_done), 32'h2);
        bif.wait_fork = 1'b0;
        tick();

        // join_any {3,3}: one join_done
        do_start(2'b01, 4'b0011, {8'd0, 8'd0, 8'd3, 8'd3});
        tick_cnt(2);
        chk("ja3_join_early", 32'(c_join), 32'd0);
        tick();
        chk("ja3_join3", 32'(bif.join_done), 32'h1);
        chk("ja3_done3", 32'(bif.thread_done), 32'h3);
        chk("ja3_busy3", 32'(bif.busy), 32'h0);
        tick_cnt(5);
        chk("ja3_join_once", 32'(c_join), 32'd0);

        // empty fork, join_any
        do_start(2'b01, 4'b0000, 32'h0);
        chk("emp_join0", 32'(bif.join_done), 32'h0);
        tick();
        chk("emp_join1", 32'(bif.join_done), 32'h1);
        chk("emp_busy1", 32'(bif.busy), 32'h0);
        tick();
        chk("emp_join2", 32'(bif.join_done), 32'h0);

        // dly = 0 behaves as 1
        do_start(2'b00, 4'b0001, 32'h0);
        chk("d0_active0", 32'(bif.thread_active), 32'h1);
        tick();
        chk("d0_done1", 32'(bif.thread_done), 32'h1);
        chk("d0_join1", 32'(bif.join_done), 32'h1);
        tick();

        // reset mid-operation of a {10} join
        do_start(2'b00, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd10});
        tick_cnt(4);
        chk("rs_el4", 32'(bif.elapsed), 32'd4);
        rst_n = 1'b0;
        tick();
        chk("rs_active", 32'(bif.thread_active), 32'h0);
        chk("rs_busy",   32'(bif.busy), 32'h0);
        chk("rs_blocked",32'(bif.parent_blocked), 32'h0);
        chk("rs_elapsed",32'(bif.elapsed), 32'h0);
        chk("rs_pulses", 32'({bif.join_done, bif.wait_done, bif.disabled, bif.thread_done}), 32'h0);
        rst_n = 1'b1;
        tick_cnt(15);
        chk("rs_no_join", 32'(c_join + c_tdone), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fork_join_ctrl.md
# fork_join_ctrl

Hardware model of SystemVerilog fork/join process control for use as a sequencing engine in test infrastructure. A parent request forks up to NUM_THREADS delay-timer threads. Each thread completes after a programmed number of cycles. The block reports when the parent may resume according to the selected join mode (join, join_any, join_none), and also supports `wait fork` and `disable fork`.

## Interface
- NUM_THREADS, 4: number of parallel thread slots.
- DLY_W, 8: width of each thread delay, in cycles.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  fork request, sampled on the rising edge.
- mode  in  2  join mode: 00 join, 01 join_any, 10 join_none; 11 is treated as join.
- thread_en  in  NUM_THREADS  threads included in this fork.
- thread_dly  in  NUM_THREADS*DLY_W  per-thread delay; slot i occupies bits [i*DLY_W +: DLY_W].
- wait_fork  in  1  level request: wait until all active threads have finished.
- disable_fork  in  1  pulse: kill all active threads.
- thread_active  out  NUM_THREADS  thread still counting.
- thread_done  out  NUM_THREADS  one-cycle pulse when a thread's delay expires.
- parent_blocked  out  1  parent is waiting on the join condition.
- join_done  out  1  one-cycle pulse when the parent resumes.
- wait_done  out  1  one-cycle pulse when a wait_fork request is satisfied.
- disabled  out  1  one-cycle pulse when a disable has been applied.
- busy  out  1  OR of thread_active.
- elapsed  out  16  cycles since the last accepted start; saturates at 0xFFFF.

## Operation
- States:
  - IDLE: no threads.
  - BLOCKED: parent waiting on the join condition.
  - DETACHED: parent released, threads still running.
- A start is accepted only in IDLE. A start arriving in any other state is ignored.
- On an accepted start:
  - Each enabled thread loads its counter with max(dly, 1), so dly=0 behaves as 1.
  - elapsed clears to 0.
- Counters decrement once per cycle. When a counter reaches 0, the thread pulses thread_done[i] and clears thread_active[i].
- mode join:
  - Go to BLOCKED.
  - join_done fires in the same cycle as the last thread_done.
  - Then go to IDLE.
- mode join_any:
  - Go to BLOCKED.
  - join_done fires with the first thread_done; if several threads expire in the same cycle, it fires once.
  - Then go to DETACHED if any thread remains active, otherwise IDLE.
- mode join_none:
  - join_done fires in the cycle after start.
  - Go to DETACHED.
- Empty fork (thread_en = 0), any mode: join_done fires in the cycle after start, and the state stays IDLE.
- DETACHED moves to IDLE when busy falls.
- wait_fork:
  - Asserted while busy=0: wait_done fires on the next cycle.
  - Otherwise wait_done fires in the same cycle as the last thread_done.
  - wait_fork must be held until wait_done; dropping it early cancels the wait.
- disable_fork:
  - On the next edge, all counters clear and no thread_done is produced.
  - A pending join_done is suppressed.
  - State goes to IDLE and disabled pulses.
  - A pending wait is satisfied with a wait_done pulse in the same cycle.
- Priority within one edge:
  - rst_n, then disable_fork, then counter expiry, then start.
  - A thread that expires on the same edge as a disable is killed and produces no done pulse.

## Timing
- Reset values: all outputs 0, state IDLE, elapsed 0.
- If start is sampled at edge E, thread i's done pulse is visible after edge E+max(dly,1), when elapsed = max(dly,1).
- join_done latency:
  - join: max over enabled threads of dly.
  - join_any: min over enabled threads of dly.
  - join_none or empty fork: 1 cycle.
- parent_blocked is high from edge E up to, but not including, the join_done cycle.
- The earliest next start after the block returns to IDLE is the cycle after the IDLE transition.
- Reset mid-operation clears everything within one edge; no done or join pulses follow.

## Test plan
- join_any, delays {40, 70, 60}, wait_fork asserted after join_done:
  - join_done at elapsed=40.
  - thread_done at 40, 60 and 70.
  - wait_done at 70.
  - busy=0 at 71.
- join_none, delays {15, 40}, disable_fork at elapsed=20:
  - join_done at 1.
  - thread_done[0] at 15.
  - No thread_done[1].
  - disabled at 21; state IDLE.
- join, delays {5, 9}:
  - parent_blocked high from 0 through 8.
  - join_done at 9.
- join_any, delays {2, 10, 6} plus wait_fork:
  - join_done at 2.
  - wait_done at 10.
  - Two threads expiring in the same cycle (delays {3, 3}) produce exactly one join_done.
- Edge cases:
  - Empty fork with join_any: join_done at 1.
  - dly=0: completes at 1.
  - start while busy: ignored.
  - rst_n low at elapsed=4 of a {10} join: all outputs 0; no join_done afterwards.
